div_restoring_seq: RTL and testbench

// - Sequential restoring divider; inverse of the 16x16 Dadda multiply path in the ALU.
// - Divides a 2W-bit unsigned dividend by a W-bit unsigned divisor.
// - Returns a W-bit quotient and a W-bit remainder, one quotient bit per clock.
// - Serves the ALU divide/remainder ops; the multiplier's 2W-bit product is a legal dividend.

---
 rtl/div_restoring_seq_if.sv | 24 ++
 rtl/div_restoring_seq.sv | 124 ++++++++++++
 tb/tb_div_restoring_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_restoring_seq_if.sv
// Request/result bundle for the sequential restoring divider.
// The master drives the operands and start; the slave (divider) returns results.
interface div_restoring_seq_if #(
  parameter int W = 16
);
  logic           start;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ovf;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, ovf
  );
endinterface

// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: 2W-bit / W-bit unsigned, one quotient bit per clock.
// Optional macro DIV_EARLY_TERM_EN: overflowing operations skip the iteration and finish immediately.
module div_restoring_seq #(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  div_restoring_seq_if.slave   bus
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_d;
  logic [W:0]      r_r;
  logic [W-1:0]    r_q;
  logic [W-1:0]    r_lo;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf_pend;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_quot;
  logic [W-1:0]    r_rem;
  logic            r_ovf;

  logic            w_ovf_in;
  logic [W:0]      w_shr;
  logic            w_ge;
  logic [W:0]      w_rnew;
  logic [W-1:0]    w_qnew;

  // High half >= divisor means the quotient cannot fit W bits; also catches divisor == 0.
  assign w_ovf_in = (bus.dividend[2*W-1:W] >= bus.divisor);

  // One restoring step: shift {R,Q} left, trial-subtract D, keep the difference if non-negative.
  assign w_shr  = {r_r[W-1:0], r_q[W-1]};
  assign w_ge   = (w_shr >= {1'b0, r_d});
  assign w_rnew = w_ge ? (w_shr - {1'b0, r_d}) : w_shr;
  assign w_qnew = {r_q[W-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_d        <= '0;
      r_r        <= '0;
      r_q        <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_d        <= bus.divisor;
            r_r        <= {1'b0, bus.dividend[2*W-1:W]};
            r_q        <= bus.dividend[W-1:0];
            r_lo       <= bus.dividend[W-1:0];
            r_cnt      <= '0;
            r_ovf_pend <= w_ovf_in;
`ifdef DIV_EARLY_TERM_EN
            if (w_ovf_in) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_quot  <= '1;
              r_rem   <= bus.dividend[W-1:0];
              r_ovf   <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
`else
            r_state <= S_RUN;
            r_busy  <= 1'b1;
`endif
          end
        end
        S_RUN: begin
          r_r   <= w_rnew;
          r_q   <= w_qnew;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_ovf_pend) begin
              r_quot <= '1;
              r_rem  <= r_lo;
              r_ovf  <= 1'b1;
            end else begin
              r_quot <= w_qnew;
              r_rem  <= w_rnew[W-1:0];
              r_ovf  <= 1'b0;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.quotient  = r_quot;
  assign bus.remainder = r_rem;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_div_restoring_seq.sv
// Directed-vector bench for div_restoring_seq (W=16) with hand-computed results.
module tb_div_restoring_seq;

  localparam int W = 16;

`ifdef DIV_EARLY_TERM_EN
  localparam int OVF_CYC  = 1;
  localparam int OVF_BUSY = 0;
`else
  localparam int OVF_CYC  = W + 1;
  localparam int OVF_BUSY = W;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  div_restoring_seq_if #(.W(W)) bus ();

  div_restoring_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait (bounded) for done; cyc counts edges from the accept edge (=1).
  task automatic run_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic o,
                        output int cyc, output int busy_n, output bit to);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    cyc = 1; busy_n = 0; to = 1'b0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      cyc++;
    end
    to = (bus.done !== 1'b1);
    q = bus.quotient; r = bus.remainder; o = bus.ovf;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.ovf, bus.quotient, bus.remainder} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b q=%h r=%h, need all 0",
               bus.busy, bus.done, bus.ovf, bus.quotient, bus.remainder);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_divide;
    logic [2*W-1:0] t_dvd [8];
    logic [W-1:0]   t_dvs [8], t_q [8], t_r [8];
    logic           t_o [8];
    logic [W-1:0] q, r;
    logic o;
    int cyc, bn;
    bit to;
    t_dvd[0] = 32'h0000_0064; t_dvs[0] = 16'h0007; t_q[0] = 16'h000E; t_r[0] = 16'h0002; t_o[0] = 1'b0;
    t_dvd[1] = 32'h1234_5678; t_dvs[1] = 16'hABCD; t_q[1] = 16'h1B20; t_r[1] = 16'h3DD8; t_o[1] = 1'b0;
    t_dvd[2] = 32'hFFFE_0001; t_dvs[2] = 16'hFFFF; t_q[2] = 16'hFFFF; t_r[2] = 16'h0000; t_o[2] = 1'b0;
    t_dvd[3] = 32'h0000_00FF; t_dvs[3] = 16'h0000; t_q[3] = 16'hFFFF; t_r[3] = 16'h00FF; t_o[3] = 1'b1;
    t_dvd[4] = 32'h0001_0000; t_dvs[4] = 16'h0001; t_q[4] = 16'hFFFF; t_r[4] = 16'h0000; t_o[4] = 1'b1;
    t_dvd[5] = 32'h0003_0000; t_dvs[5] = 16'h0004; t_q[5] = 16'hC000; t_r[5] = 16'h0000; t_o[5] = 1'b0;
    t_dvd[6] = 32'hFFFF_1234; t_dvs[6] = 16'hFFFF; t_q[6] = 16'hFFFF; t_r[6] = 16'h1234; t_o[6] = 1'b1;
    t_dvd[7] = 32'h0000_0000; t_dvs[7] = 16'h0005; t_q[7] = 16'h0000; t_r[7] = 16'h0000; t_o[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run_op(t_dvd[i], t_dvs[i], q, r, o, cyc, bn, to);
      n_cmp++;
      if (to) begin
        n_fail++;
        $display("FAIL div%0d_timeout: no done within %0d cycles", i, cyc);
      end
      n_cmp++;
      if ({q, r, o} !== {t_q[i], t_r[i], t_o[i]}) begin
        n_fail++;
        $display("FAIL div%0d_result: got q=%h r=%h ovf=%b, need q=%h r=%h ovf=%b",
                 i, q, r, o, t_q[i], t_r[i], t_o[i]);
      end
      n_cmp++;
      if (cyc !== (t_o[i] ? OVF_CYC : W + 1)) begin
        n_fail++;
        $display("FAIL div%0d_latency: got %0d, need %0d", i, cyc, t_o[i] ? OVF_CYC : W + 1);
      end
      n_cmp++;
      if (bn !== (t_o[i] ? OVF_BUSY : W) || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL div%0d_busy: got %0d busy cycles (busy at done=%b), need %0d",
                 i, bn, bus.busy, t_o[i] ? OVF_BUSY : W);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (bus.done !== 1'b0 || {bus.quotient, bus.remainder, bus.ovf} !== {t_q[i], t_r[i], t_o[i]}) begin
        n_fail++;
        $display("FAIL div%0d_hold: got done=%b q=%h r=%h ovf=%b, need done=0 and held result",
                 i, bus.done, bus.quotient, bus.remainder, bus.ovf);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] q, r;
    logic o;
    int cyc, bn;
    bit to;
    time t0, t1;
    run_op(32'h0000_0064, 16'h0007, q, r, o, cyc, bn, to);
    t0 = $time;
    @(posedge clk); #1;
    run_op(32'h1234_5678, 16'hABCD, q, r, o, cyc, bn, to);
    t1 = $time;
    n_cmp++;
    if (to || {q, r, o} !== {16'h1B20, 16'h3DD8, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_result: got q=%h r=%h ovf=%b to=%b, need q=1b20 r=3dd8 ovf=0", q, r, o, to);
    end
    n_cmp++;
    if ((t1 - t0) !== 64'(10 * (W + 2))) begin
      n_fail++;
      $display("FAIL b2b_period: got %0t, need %0d", t1 - t0, 10 * (W + 2));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored;
    int ndone, first;
    logic [W-1:0] q, r;
    logic o;
    ndone = 0; first = 0; q = '0; r = '0; o = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'h0000_0064; bus.divisor = 16'h0007;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'h1234_5678; bus.divisor = 16'hABCD;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        ndone++;
        if (ndone == 1) begin
          q = bus.quotient; r = bus.remainder; o = bus.ovf; first = k;
        end
      end
    end
    n_cmp++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL ign_done_count: got %0d done pulses, need 1 (first at %0d)", ndone, first);
    end
    n_cmp++;
    if ({q, r, o} !== {16'h000E, 16'h0002, 1'b0}) begin
      n_fail++;
      $display("FAIL ign_result: got q=%h r=%h ovf=%b, need q=000e r=0002 ovf=0", q, r, o);
    end
  endtask

  task automatic test_reset_mid_run;
    int ndone;
    logic [W-1:0] q, r;
    logic o;
    int cyc, bn;
    bit to;
    ndone = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'h1234_5678; bus.divisor = 16'hABCD;
    @(negedge clk);
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.busy, bus.done, bus.ovf, bus.quotient, bus.remainder} !== '0) begin
      n_fail++;
      $display("FAIL rstrun_outputs: got busy=%b done=%b ovf=%b q=%h r=%h, need all 0",
               bus.busy, bus.done, bus.ovf, bus.quotient, bus.remainder);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL rstrun_abandon: got %0d cycles with busy/done, need 0", ndone);
    end
    run_op(32'h0000_0064, 16'h0007, q, r, o, cyc, bn, to);
    n_cmp++;
    if (to || cyc !== W + 1 || {q, r, o} !== {16'h000E, 16'h0002, 1'b0}) begin
      n_fail++;
      $display("FAIL rstrun_restart: got q=%h r=%h ovf=%b cyc=%0d to=%b, need q=000e r=0002 ovf=0 cyc=%0d",
               q, r, o, cyc, to, W + 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_divide();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
